axi4_rd_arbiter: RTL and testbench

//  Shares one AXI4 read master port (AR+R channels) between N requesters
//  (DMA engines, bus models). Round-robin grant, one outstanding burst at a

---
 rtl/axi4_rd_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_axi4_rd_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rd_arbiter.sv
// AXI4 read-channel arbiter: N requesters share one AR/R master port, round-robin,
// one outstanding burst at a time, with a sticky beat-count versus ARLEN check.
module axi4_rd_arbiter #(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int IW = 1,
    parameter int LW = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [N-1:0]         s_arvalid,
    output logic [N-1:0]         s_arready,
    input  logic [N*AW-1:0]      s_araddr,
    input  logic [N*LW-1:0]      s_arlen,
    input  logic [N*IW-1:0]      s_arid,
    input  logic [N*3-1:0]       s_arsize,
    input  logic [N*2-1:0]       s_arburst,
    output logic [N-1:0]         s_rvalid,
    input  logic [N-1:0]         s_rready,
    output logic [DW-1:0]        s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 s_rlast,
    output logic [IW-1:0]        s_rid,
    output logic                 m_arvalid,
    input  logic                 m_arready,
    output logic [AW-1:0]        m_araddr,
    output logic [LW-1:0]        m_arlen,
    output logic [IW-1:0]        m_arid,
    output logic [2:0]           m_arsize,
    output logic [1:0]           m_arburst,
    input  logic                 m_rvalid,
    output logic                 m_rready,
    input  logic [DW-1:0]        m_rdata,
    input  logic [1:0]           m_rresp,
    input  logic                 m_rlast,
    input  logic [IW-1:0]        m_rid,
    output logic [$clog2(N)-1:0] grant,
    output logic                 busy,
    output logic                 len_err,
    input  logic                 len_err_clr
);

    localparam int GW = $clog2(N);
    localparam int BW = LW + 1;
    localparam logic [GW-1:0] LAST_REQ = GW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [LW-1:0] len_q, len_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          len_err_q, len_err_d;

    logic          pick_vld;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] cand_g;
    logic [LW-1:0] pick_len;

    logic [AW-1:0] sel_addr;
    logic [LW-1:0] sel_len;
    logic [IW-1:0] sel_id;
    logic [2:0]    sel_size;
    logic [1:0]    sel_burst;

    logic          beat_acc;
    logic          len_bad;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = grant_q;
        cand_g   = grant_q;
        for (int i = 1; i <= N; i++) begin
            cand_g = GW'((int'(grant_q) + i) % N);
            if (!pick_vld && s_arvalid[cand_g]) begin
                pick_vld = 1'b1;
                pick_idx = cand_g;
            end
        end
    end

    always_comb begin
        pick_len = '0;
        for (int k = 0; k < N; k++) begin
            if (pick_idx == GW'(k)) begin
                pick_len = s_arlen[k*LW +: LW];
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_len   = '0;
        sel_id    = '0;
        sel_size  = '0;
        sel_burst = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_q == GW'(k)) begin
                sel_addr  = s_araddr[k*AW +: AW];
                sel_len   = s_arlen[k*LW +: LW];
                sel_id    = s_arid[k*IW +: IW];
                sel_size  = s_arsize[k*3 +: 3];
                sel_burst = s_arburst[k*2 +: 2];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        len_d     = len_q;
        beat_d    = beat_q;
        len_err_d = len_err_q;
        m_arvalid = 1'b0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arid    = '0;
        m_arsize  = '0;
        m_arburst = '0;
        s_arready = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        beat_acc  = 1'b0;
        len_bad   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    len_d   = pick_len;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_arvalid          = 1'b1;
                m_araddr           = sel_addr;
                m_arlen            = sel_len;
                m_arid             = sel_id;
                m_arsize           = sel_size;
                m_arburst          = sel_burst;
                s_arready[grant_q] = m_arready;
                if (m_arready) begin
                    beat_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                m_rready          = s_rready[grant_q];
                s_rvalid[grant_q] = m_rvalid;
                beat_acc          = m_rvalid && s_rready[grant_q];
                if (beat_acc) begin
                    // Counter saturates so an overlong burst cannot alias back onto len.
                    if (beat_q != {BW{1'b1}}) begin
                        beat_d = beat_q + 1'b1;
                    end
                    len_bad = (m_rlast != (beat_q == {1'b0, len_q}));
                    if (m_rlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (len_bad) begin
            len_err_d = 1'b1;
        end else if (len_err_clr) begin
            len_err_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            grant_q   <= LAST_REQ;
            len_q     <= '0;
            beat_q    <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            len_err_q <= len_err_d;
        end
    end

    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;
    assign s_rlast = m_rlast;
    assign s_rid   = m_rid;
    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign len_err = len_err_q;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Bench for axi4_rd_arbiter (N=3): directed scenarios then randomized bursts checked
// against a round-robin / burst-length reference model.
module tb_axi4_rd_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int LW = 4;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    s_arvalid;
    logic [N-1:0]    s_arready;
    logic [N*AW-1:0] s_araddr;
    logic [N*LW-1:0] s_arlen;
    logic [N*IW-1:0] s_arid;
    logic [N*3-1:0]  s_arsize;
    logic [N*2-1:0]  s_arburst;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [IW-1:0]   s_rid;
    logic            m_arvalid;
    logic            m_arready;
    logic [AW-1:0]   m_araddr;
    logic [LW-1:0]   m_arlen;
    logic [IW-1:0]   m_arid;
    logic [2:0]      m_arsize;
    logic [1:0]      m_arburst;
    logic            m_rvalid;
    logic            m_rready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic [IW-1:0]   m_rid;
    logic [GW-1:0]   grant;
    logic            busy;
    logic            len_err;
    logic            len_err_clr;

    axi4_rd_arbiter #(.N(N), .AW(AW), .DW(DW), .IW(IW), .LW(LW)) dut (
        .ACLK(clk), .ARESET(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arid(s_arid), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arid(m_arid), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rid(m_rid),
        .grant(grant), .busy(busy), .len_err(len_err), .len_err_clr(len_err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int   model_grant;
    logic model_err;

    logic [AW-1:0] r_addr [N];
    logic [LW-1:0] r_len  [N];
    logic [IW-1:0] r_id   [N];
    logic [2:0]    r_size [N];
    logic [1:0]    r_burst[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Next owner: first valid requester after the last owner, wrapping modulo N.
    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [LW-1:0] l);
        r_addr[k]  = a;
        r_len[k]   = l;
        r_id[k]    = IW'($urandom);
        r_size[k]  = 3'($urandom);
        r_burst[k] = 2'($urandom);
        s_araddr[k*AW +: AW] = a;
        s_arlen[k*LW +: LW]  = l;
        s_arid[k*IW +: IW]   = r_id[k];
        s_arsize[k*3 +: 3]   = r_size[k];
        s_arburst[k*2 +: 2]  = r_burst[k];
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_grant"}, grant, N - 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_m_arvalid"}, m_arvalid, 0);
        chk({tag, "_s_arready"}, s_arready, 0);
        chk({tag, "_s_rvalid"}, s_rvalid, 0);
        chk({tag, "_m_rready"}, m_rready, 0);
        chk({tag, "_len_err"}, len_err, 0);
        chk({tag, "_m_araddr"}, m_araddr, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check_reset_state("reset");
        rst = 1'b0;
        model_grant = N - 1;
        model_err   = 1'b0;
        step();
    endtask

    task automatic clear_err();
        len_err_clr = 1'b1;
        step();
        len_err_clr = 1'b0;
        model_err   = 1'b0;
        chk("err_clear", len_err, 0);
    endtask

    // One complete burst from the IDLE decision through the last accepted beat.
    task automatic burst(input int nbeats, input int arwait, input bit keep,
                         input bit stalls, input bit clr_last, output int g);
        int exp;
        int b;
        exp = rr_pick(model_grant, s_arvalid);
        g   = exp;
        step();
        chk("addr_busy", busy, 1);
        chk("addr_grant", grant, exp);
        for (int w = 0; w <= arwait; w++) begin
            m_arready = (w == arwait);
            #1;
            chk("addr_arvalid", m_arvalid, 1);
            chk("addr_araddr", m_araddr, r_addr[exp]);
            chk("addr_arlen", m_arlen, r_len[exp]);
            chk("addr_arid", m_arid, r_id[exp]);
            chk("addr_arsize", m_arsize, r_size[exp]);
            chk("addr_arburst", m_arburst, r_burst[exp]);
            chk("addr_s_arready", s_arready, m_arready ? (1 << exp) : 0);
            chk("addr_s_rvalid", s_rvalid, 0);
            step();
        end
        m_arready = 1'b0;
        if (!keep) s_arvalid[exp] = 1'b0;
        model_grant = exp;

        b = 0;
        while (b < nbeats) begin
            bit            rv;
            bit            rr;
            bit            acc;
            bit            ev;
            logic [DW-1:0] d;
            logic [1:0]    rs;
            rv = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            rr = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            d  = DW'($urandom);
            rs = 2'($urandom);
            m_rvalid = rv;
            m_rdata  = d;
            m_rresp  = rs;
            m_rid    = r_id[exp];
            m_rlast  = (b == nbeats - 1);
            s_rready = N'($urandom);
            s_rready[exp] = rr;
            acc = rv && rr;
            len_err_clr = clr_last && acc && (b == nbeats - 1);
            #1;
            chk("data_s_rvalid", s_rvalid, rv ? (1 << exp) : 0);
            chk("data_m_rready", m_rready, rr);
            chk("data_s_rdata", s_rdata, d);
            chk("data_s_rresp", s_rresp, rs);
            chk("data_s_rid", s_rid, r_id[exp]);
            chk("data_s_rlast", s_rlast, (b == nbeats - 1));
            chk("data_s_arready", s_arready, 0);
            chk("data_busy", busy, 1);
            step();
            if (acc) begin
                ev = ((b == nbeats - 1) != (b == int'(r_len[exp])));
                if (ev) model_err = 1'b1;
                else if (len_err_clr) model_err = 1'b0;
                b++;
            end
            len_err_clr = 1'b0;
            chk("data_len_err", len_err, model_err);
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = '0;
        #1;
        chk("end_busy", busy, 0);
        chk("end_grant", grant, exp);
    endtask

    initial begin
        int g;
        rst = 1'b1;
        s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arid = '0; s_arsize = '0; s_arburst = '0;
        s_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
        m_rlast = 1'b0; m_rid = '0; len_err_clr = 1'b0;
        model_grant = N - 1;
        model_err   = 1'b0;
        step();
        do_reset();

        // Single requester, ARLEN=3, four beats.
        set_req(0, 16'h1000, 4'd3);
        s_arvalid = 3'b001;
        #1;
        chk("lat_req_cycle_arvalid", m_arvalid, 0);
        burst(4, 0, 0, 0, 0, g);
        chk("single_grant", grant, 0);
        chk("single_len_err", len_err, 0);

        // Two requesters continuously valid, single-beat bursts.
        do_reset();
        set_req(0, 16'h2000, 4'd0);
        set_req(1, 16'h3000, 4'd0);
        s_arvalid = 3'b011;
        for (int i = 0; i < 4; i++) begin
            burst(1, 0, 1, 0, 0, g);
            chk("alt_grant", grant, i % 2);
        end
        s_arvalid = '0;
        step();

        // Search wraps through 0 on the way to the next owner.
        do_reset();
        set_req(2, 16'h4000, 4'd1);
        s_arvalid = 3'b100;
        burst(2, 0, 0, 0, 0, g);
        chk("wrap_first", grant, 2);
        set_req(1, 16'h5000, 4'd2);
        s_arvalid = 3'b010;
        burst(3, 0, 0, 0, 0, g);
        chk("wrap_second", grant, 1);

        // Early RLAST sets the sticky error; the burst still ends.
        set_req(0, 16'h6000, 4'd3);
        s_arvalid = 3'b001;
        burst(3, 0, 0, 0, 0, g);
        chk("early_rlast_err", len_err, 1);
        chk("early_rlast_idle", busy, 0);
        clear_err();

        // Master holds off AR for five cycles.
        set_req(1, 16'h7000, 4'd2);
        s_arvalid = 3'b010;
        burst(3, 5, 0, 0, 0, g);
        chk("stall_len_err", len_err, 0);

        // Clear pulse on a beat that also flags an error: set wins.
        set_req(2, 16'h8000, 4'd1);
        s_arvalid = 3'b100;
        burst(3, 0, 0, 0, 1, g);
        chk("set_wins", len_err, 1);
        clear_err();

        // Asynchronous reset in the middle of a burst.
        set_req(0, 16'h9000, 4'd3);
        s_arvalid = 3'b001;
        step();
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        s_arvalid = '0;
        m_rvalid = 1'b1; m_rlast = 1'b0; s_rready = 3'b001;
        step();
        rst = 1'b1;
        #1;
        check_reset_state("midburst_reset");
        step();
        rst = 1'b0;
        m_rvalid = 1'b0;
        s_rready = '0;
        model_grant = N - 1;
        model_err   = 1'b0;
        step();

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            int len;
            int nb;
            len = $urandom_range(0, 5);
            for (int k = 0; k < N; k++) set_req(k, AW'($urandom), LW'(len));
            nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : len + 1;
            if ($urandom_range(0, 3) == 0) begin
                s_arvalid = '0;
                step();
                chk("rand_idle_grant", grant, model_grant);
                chk("rand_idle_busy", busy, 0);
            end
            s_arvalid = N'($urandom_range(1, 7));
            burst(nb, $urandom_range(0, 2), 0, 1, $urandom_range(0, 1), g);
            s_arvalid = '0;
            if (model_err && $urandom_range(0, 1) == 1) clear_err();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
